// File: rtl/hall_meas_pkg.sv
// Shared types and default widths for the hall measurement sequencer.
package hall_meas_pkg;
  localparam int DWIDTH_DEF   = 16;
  localparam int PERIOD_W_DEF = 16;
  localparam int POS_W        = 32;

  typedef enum logic [1:0] {IDLE, RUN, TRIG, CAP} state_t;
endpackage

// File: rtl/hall_meas_ctrl_tick.sv
// Period down-counter: load wins over decrement, holds at zero, expire flags a decrement at terminal count.
module hall_meas_tick #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_val,
  output logic         expire
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (load)
      cnt <= load_val;
    else if (dec && cnt != '0)
      cnt <= cnt - W'(1);
  end

  assign expire = dec && (cnt == '0);
endmodule

// File: rtl/hall_meas_ctrl.sv
// Hall position measurement sequencer: periodic trigger, sample capture, preload scheduling.
// Optional stall detector built when HALL_MEAS_STALL_EN is defined.
module hall_meas_ctrl
  import hall_meas_pkg::*;
#(
  parameter int DWIDTH   = DWIDTH_DEF,
  parameter int PERIOD_W = PERIOD_W_DEF,
  parameter int STALL_N  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [PERIOD_W-1:0] period,
  output logic                mea_trigger,
  input  logic [DWIDTH-1:0]   delta_pos,
  input  logic [POS_W-1:0]    position,
  input  logic                init_req,
  input  logic [POS_W-1:0]    init_value,
  output logic [POS_W-1:0]    pos_init,
  output logic                pos_init_valid,
  output logic                sample_valid,
  input  logic                sample_ready,
  output logic [DWIDTH-1:0]   sample_delta,
  output logic [POS_W-1:0]    sample_pos,
  output logic                overrun,
  output logic                stall
);
  // state | meaning
  // IDLE  | measurement off, preload may issue
  // RUN   | period counting, preload may issue
  // TRIG  | mea_trigger pulse to the position counter
  // CAP   | delta_pos/position valid, sample captured
  state_t state, state_nxt;
  logic   load, dec, expire, capture, issue;
  logic   pend_valid;
  logic [POS_W-1:0]    pend_value;
  logic [PERIOD_W-1:0] reload_val;

  assign reload_val = (period == '0) ? PERIOD_W'(1) : period;
  assign issue      = pend_valid && (state == IDLE || state == RUN);

  hall_meas_tick #(.W(PERIOD_W)) u_tick (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .dec      (dec),
    .load_val (reload_val),
    .expire   (expire)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    dec       = 1'b0;
    capture   = 1'b0;
    case (state)
      IDLE: begin
        load = issue | enable;
        if (enable) state_nxt = RUN;
      end
      RUN: begin
        if (!enable)     state_nxt = IDLE;
        else if (issue)  load = 1'b1;
        else begin
          dec = 1'b1;
          if (expire) state_nxt = TRIG;
        end
      end
      TRIG: state_nxt = CAP;
      CAP: begin
        capture = 1'b1;
        if (enable) begin
          state_nxt = RUN;
          load      = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign mea_trigger    = (state == TRIG);
  assign pos_init       = pend_value;
  assign pos_init_valid = issue;

  // A request arriving on the issue cycle survives the clear and goes out next time.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pend_valid <= 1'b0;
      pend_value <= '0;
    end else if (init_req) begin
      pend_valid <= 1'b1;
      pend_value <= init_value;
    end else if (issue) begin
      pend_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sample_valid <= 1'b0;
      sample_delta <= '0;
      sample_pos   <= '0;
      overrun      <= 1'b0;
    end else begin
      if (capture) begin
        if (!sample_valid || sample_ready) begin
          sample_valid <= 1'b1;
          sample_delta <= delta_pos;
          sample_pos   <= position;
        end else begin
          overrun <= 1'b1;
        end
      end else if (sample_valid && sample_ready) begin
        sample_valid <= 1'b0;
      end
      if (issue) overrun <= 1'b0;
    end
  end

`ifdef HALL_MEAS_STALL_EN
  localparam int SC_W = $clog2(STALL_N + 1);
  logic [SC_W-1:0] zero_cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      zero_cnt <= '0;
    else if (issue)
      zero_cnt <= '0;
    else if (capture) begin
      if (delta_pos != '0)
        zero_cnt <= '0;
      else if (zero_cnt != SC_W'(STALL_N))
        zero_cnt <= zero_cnt + SC_W'(1);
    end
  end

  assign stall = (zero_cnt == SC_W'(STALL_N));
`else
  // STALL_N only matters when the stall detector is built.
  assign stall = 1'b0 & (STALL_N != 0);
`endif
endmodule

// File: tb/tb_hall_meas_ctrl.sv
// Self-checking bench for hall_meas_ctrl: timeline model plus directed literal checks.
module tb_hall_meas_ctrl;
  localparam int DW = 16;
  localparam int PW = 16;
  localparam int SN = 8;
`ifdef HALL_MEAS_STALL_EN
  localparam bit STALL_ON = 1'b1;
`else
  localparam bit STALL_ON = 1'b0;
`endif

  logic          clk, reset, enable, mea_trigger, init_req, pos_init_valid;
  logic          sample_valid, sample_ready, overrun, stall;
  logic [PW-1:0] period;
  logic [DW-1:0] delta_pos, sample_delta, dval;
  logic [31:0]   position, init_value, pos_init, sample_pos;
  int            cyc = 0;
  int            checks = 0;
  int            errors = 0;

  hall_meas_ctrl #(.DWIDTH(DW), .PERIOD_W(PW), .STALL_N(SN)) dut (
    .clk(clk), .reset(reset), .enable(enable), .period(period),
    .mea_trigger(mea_trigger), .delta_pos(delta_pos), .position(position),
    .init_req(init_req), .init_value(init_value), .pos_init(pos_init),
    .pos_init_valid(pos_init_valid), .sample_valid(sample_valid),
    .sample_ready(sample_ready), .sample_delta(sample_delta),
    .sample_pos(sample_pos), .overrun(overrun), .stall(stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  assign delta_pos = dval;
  assign position  = 32'(cyc) * 32'd3 + 32'h100;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Timeline model: counting phase lasts max(period,1)+1 cycles, then one trigger
  // cycle and one capture cycle; post: 0 = idle/counting, 1 = trigger, 2 = capture.
  bit          m_active, m_pend, m_sv, m_ov;
  int          m_post, m_elapsed, m_len, m_zero;
  logic [31:0] m_pval, m_sp;
  logic [15:0] m_sd;

  always @(posedge clk or posedge reset) begin : model
    bit issue;
    if (reset) begin
      m_active = 0; m_pend = 0; m_sv = 0; m_ov = 0;
      m_post = 0; m_elapsed = 0; m_len = 0; m_zero = 0;
      m_pval = 0; m_sp = 0; m_sd = 0;
    end else begin
      issue = m_pend && m_post == 0;
      if (m_post == 2) begin
        if (!m_sv || sample_ready) begin
          m_sv = 1; m_sd = delta_pos; m_sp = position;
        end else m_ov = 1;
        if (delta_pos == 0) m_zero = (m_zero < SN) ? m_zero + 1 : SN;
        else m_zero = 0;
      end else if (m_sv && sample_ready) m_sv = 0;
      if (issue) begin m_ov = 0; m_zero = 0; end
      if (init_req) begin m_pend = 1; m_pval = init_value; end
      else if (issue) m_pend = 0;

      if (m_post == 1) m_post = 2;
      else if (m_post == 2) begin
        m_post = 0;
        m_active = enable;
        m_elapsed = 0;
        m_len = ((period == 0) ? 1 : int'(period)) + 1;
      end else if (!m_active || !enable || issue) begin
        m_active = enable;
        m_elapsed = 0;
        m_len = ((period == 0) ? 1 : int'(period)) + 1;
      end else begin
        m_elapsed++;
        if (m_elapsed == m_len) m_post = 1;
      end
    end
  end

  always @(negedge clk) begin
    if (!reset) begin
      check("mea_trigger", 32'(mea_trigger), 32'(m_post == 1));
      check("pos_init_valid", 32'(pos_init_valid), 32'(m_pend && m_post == 0));
      if (m_pend && m_post == 0) check("pos_init", pos_init, m_pval);
      check("sample_valid", 32'(sample_valid), 32'(m_sv));
      if (m_sv) begin
        check("sample_delta", 32'(sample_delta), 32'(m_sd));
        check("sample_pos", sample_pos, m_sp);
      end
      check("overrun", 32'(overrun), 32'(m_ov));
      check("stall", 32'(stall), 32'(STALL_ON && m_zero >= SN));
    end
  end

  task automatic wait_trig(output int t);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mea_trigger && n < 300);
    if (!mea_trigger) check("trigger_timeout", 32'd0, 32'd1);
    t = cyc;
  endtask

  task automatic after_capture();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    int c0, t0, t1, t2;
    reset = 1'b1; enable = 1'b0; period = 16'd9; init_req = 1'b0;
    init_value = '0; sample_ready = 1'b1; dval = 16'h0005;
    repeat (2) @(negedge clk);
    check("rst_trigger", 32'(mea_trigger), 32'd0);
    check("rst_sample_valid", 32'(sample_valid), 32'd0);
    check("rst_pos_init_valid", 32'(pos_init_valid), 32'd0);
    check("rst_overrun", 32'(overrun), 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    // periodic triggering, period 9
    @(negedge clk); enable = 1'b1; c0 = cyc;
    wait_trig(t0);
    check("first_trig_latency", 32'(t0 - c0), 32'd11);
    wait_trig(t1);
    check("trig_interval_p9", 32'(t1 - t0), 32'd12);
    after_capture();
    check("t1_valid", 32'(sample_valid), 32'd1);
    check("t1_delta", 32'(sample_delta), 32'h5);
    @(negedge clk);
    check("t1_valid_drop", 32'(sample_valid), 32'd0);

    // overrun with consumer stalled
    sample_ready = 1'b0; dval = 16'h0011;
    wait_trig(t0); after_capture();
    check("t2_first_delta", 32'(sample_delta), 32'h11);
    check("t2_no_overrun", 32'(overrun), 32'd0);
    dval = 16'h0022;
    wait_trig(t0); after_capture();
    check("t2_overrun", 32'(overrun), 32'd1);
    check("t2_kept_delta", 32'(sample_delta), 32'h11);
    sample_ready = 1'b1;
    @(negedge clk);
    check("t2_valid_drop", 32'(sample_valid), 32'd0);

    // preload requested during TRIG waits for RUN
    wait_trig(t0);
    init_req = 1'b1; init_value = 32'h1000;
    @(negedge clk); init_req = 1'b0;
    check("t3_no_init_in_cap", 32'(pos_init_valid), 32'd0);
    check("t3_overrun_held", 32'(overrun), 32'd1);
    @(negedge clk);
    check("t3_init_valid", 32'(pos_init_valid), 32'd1);
    check("t3_init_value", pos_init, 32'h1000);
    init_req = 1'b1; init_value = 32'h2000;
    @(negedge clk); init_req = 1'b0;
    check("t3_overrun_clr", 32'(overrun), 32'd0);
    check("t3_reissue_valid", 32'(pos_init_valid), 32'd1);
    check("t3_reissue_value", pos_init, 32'h2000);
    @(negedge clk);
    check("t3_init_done", 32'(pos_init_valid), 32'd0);

    // period 0 behaves as 1; takes effect at next reload
    period = 16'd0; dval = 16'h0033;
    wait_trig(t0); wait_trig(t1); wait_trig(t2);
    check("trig_interval_p0", 32'(t2 - t1), 32'd4);

    // asynchronous reset inside CAP
    wait_trig(t0);
    @(posedge clk); #2 reset = 1'b1;
    #1;
    check("arst_trigger", 32'(mea_trigger), 32'd0);
    check("arst_pos_init", pos_init, 32'd0);
    check("arst_pos_init_valid", 32'(pos_init_valid), 32'd0);
    check("arst_sample_valid", 32'(sample_valid), 32'd0);
    check("arst_sample_delta", 32'(sample_delta), 32'd0);
    check("arst_sample_pos", sample_pos, 32'd0);
    check("arst_overrun", 32'(overrun), 32'd0);
    check("arst_stall", 32'(stall), 32'd0);
    period = 16'd2; dval = 16'h0000;
    repeat (2) @(posedge clk);
    #2 reset = 1'b0;

    // zero-delta run
    for (int i = 0; i < SN - 1; i++) begin
      wait_trig(t0); after_capture();
    end
    check("stall_before_n", 32'(stall), 32'd0);
    wait_trig(t0); after_capture();
    check("stall_at_n", 32'(stall), 32'(STALL_ON));
    dval = 16'h0003;
    wait_trig(t0); after_capture();
    check("stall_cleared", 32'(stall), 32'd0);

    enable = 1'b0;
    repeat (20) @(negedge clk);
    check("idle_no_trigger", 32'(mea_trigger), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
